// File: rtl/fetcher.sv
// Instruction fetch stage: issues a program-memory read for current_pc when
// the scheduler enters FETCH, then holds the returned instruction for decode.
// Optional direct-mapped instruction cache, compiled in with FETCHER_CACHE_EN.
module fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int CACHE_LINES           = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

    localparam logic [2:0] CORE_FETCH  = 3'b001;
    localparam logic [2:0] CORE_DECODE = 3'b010;

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        FETCHING = 3'b001,
        FETCHED  = 3'b010
    } state_t;

    state_t state;

    // The cache index is a plain bit slice of the PC, so the line count
    // must be a power of two and at least two.
    if (CACHE_LINES < 2 || (CACHE_LINES & (CACHE_LINES - 1)) != 0) begin : g_bad_cache_lines
        $error("fetcher: CACHE_LINES must be a power of 2 and >= 2");
    end

`ifdef FETCHER_CACHE_EN
    localparam int IDX_BITS = $clog2(CACHE_LINES);
    localparam int TAG_BITS = PROGRAM_MEM_ADDR_BITS - IDX_BITS;

    logic [CACHE_LINES-1:0]           cache_valid;
    logic [TAG_BITS-1:0]              cache_tag  [CACHE_LINES];
    logic [PROGRAM_MEM_DATA_BITS-1:0] cache_data [CACHE_LINES];

    logic [IDX_BITS-1:0]              pc_index;
    logic                             cache_hit;
    logic [PROGRAM_MEM_DATA_BITS-1:0] hit_data;
    logic [IDX_BITS-1:0]              fill_index;
    logic [TAG_BITS-1:0]              fill_tag;

    // Lookup of current_pc, and the fill slot derived from the held request address.
    always_comb begin
        pc_index   = current_pc[IDX_BITS-1:0];
        cache_hit  = cache_valid[pc_index] &&
                     (cache_tag[pc_index] == current_pc[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS]);
        hit_data   = cache_data[pc_index];
        fill_index = mem_read_address[IDX_BITS-1:0];
        fill_tag   = mem_read_address[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];
    end

    // Tag/data storage needs no reset: entries are qualified by cache_valid.
    always_ff @(posedge clk) begin
        if (state == FETCHING && mem_read_ready) begin
            cache_tag[fill_index]  <= fill_tag;
            cache_data[fill_index] <= mem_read_data;
        end
    end
`endif

    // Fetch FSM with registered request, instruction and valid bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
            instruction      <= '0;
`ifdef FETCHER_CACHE_EN
            cache_valid      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (core_state == CORE_FETCH) begin
`ifdef FETCHER_CACHE_EN
                        if (cache_hit) begin
                            instruction <= hit_data;
                            state       <= FETCHED;
                        end else
`endif
                        begin
                            mem_read_valid   <= 1'b1;
                            mem_read_address <= current_pc;
                            state            <= FETCHING;
                        end
                    end
                end
                FETCHING: begin
                    if (mem_read_ready) begin
                        instruction    <= mem_read_data;
                        mem_read_valid <= 1'b0;
                        state          <= FETCHED;
`ifdef FETCHER_CACHE_EN
                        cache_valid[fill_index] <= 1'b1;
`endif
                    end
                end
                FETCHED: begin
                    if (core_state == CORE_DECODE) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fetcher_state = state;

endmodule
